// File: rtl/ysyx_22040125_mem_stage_if.sv
// Data-memory port of the MEM stage.
// The request carries an aligned address with store lanes. The response is
// rsp_valid plus rdata for loads, and acts as a plain acknowledge for stores.
interface ysyx_22040125_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        wen;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        rsp_valid;
  logic [63:0] rdata;

  modport master (
    output req_valid, addr, wen, wdata, wmask,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/ysyx_22040125_mem_stage.sv
// MEM stage of the ysyx_22040125 RV64 pipeline.
// Non-memory and misaligned ops pass straight through in the same cycle.
// Aligned loads and stores are latched, issued as one aligned doubleword
// request, and retired with a single out_valid pulse once the response arrives.
module ysyx_22040125_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic [1:0]  in_wb_sel,
  input  logic [63:0] in_alu_res,
  input  logic [63:0] in_store_data,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_inst,
  ysyx_22040125_mem_stage_if.master dmem,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_funct3,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [1:0]  out_wb_sel,
  output logic [63:0] out_alu_res,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic [63:0] out_load_data,
  output logic        out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [63:0] alu_res_q, alu_res_d;
  logic [63:0] store_data_q, store_data_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] load_data_q, load_data_d;

  logic        in_is_mem;
  logic        in_misalign;
  logic [2:0]  offset;
  logic        is_store;
  logic [7:0]  size_mask;
  logic [63:0] rdata_shift;
  logic [63:0] load_ext;

  // Alignment check on the incoming op, plus lane steering and load extension for the latched op.
  always_comb begin
    in_is_mem = in_mem_rd | in_mem_wr;
    case (in_funct3[1:0])
      2'b00:   in_misalign = 1'b0;
      2'b01:   in_misalign = in_alu_res[0];
      2'b10:   in_misalign = |in_alu_res[1:0];
      default: in_misalign = |in_alu_res[2:0];
    endcase

    offset   = alu_res_q[2:0];
    // A load flag takes precedence when both flags are set.
    is_store = mem_wr_q & ~mem_rd_q;
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase

    rdata_shift = dmem.rdata >> {offset, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  load_ext = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b010:  load_ext = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      3'b100:  load_ext = {56'd0, rdata_shift[7:0]};
      3'b101:  load_ext = {48'd0, rdata_shift[15:0]};
      3'b110:  load_ext = {32'd0, rdata_shift[31:0]};
      default: load_ext = rdata_shift;  // 011 and 111: full doubleword
    endcase
  end

  // Next-state, latch updates and all outputs; every output is zero unless its state drives it.
  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    funct3_d      = funct3_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    wb_sel_d      = wb_sel_q;
    alu_res_d     = alu_res_q;
    store_data_d  = store_data_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    load_data_d   = load_data_q;
    in_ready      = 1'b0;
    dmem.req_valid = 1'b0;
    dmem.addr     = 64'd0;
    dmem.wen      = 1'b0;
    dmem.wdata    = 64'd0;
    dmem.wmask    = 8'd0;
    out_valid     = 1'b0;
    out_rd        = 5'd0;
    out_funct3    = 3'd0;
    out_mem_rd    = 1'b0;
    out_mem_wr    = 1'b0;
    out_wb_sel    = 2'd0;
    out_alu_res   = 64'd0;
    out_pc        = 64'd0;
    out_inst      = 32'd0;
    out_load_data = 64'd0;
    out_misalign  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_is_mem || in_misalign) begin
            out_valid    = 1'b1;
            out_rd       = in_rd;
            out_funct3   = in_funct3;
            out_mem_rd   = in_mem_rd;
            out_mem_wr   = in_mem_wr;
            out_wb_sel   = in_wb_sel;
            out_alu_res  = in_alu_res;
            out_pc       = in_pc;
            out_inst     = in_inst;
            out_misalign = in_is_mem & in_misalign;
          end else begin
            rd_d         = in_rd;
            funct3_d     = in_funct3;
            mem_rd_d     = in_mem_rd;
            mem_wr_d     = in_mem_wr;
            wb_sel_d     = in_wb_sel;
            alu_res_d    = in_alu_res;
            store_data_d = in_store_data;
            pc_d         = in_pc;
            inst_d       = in_inst;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        dmem.req_valid = 1'b1;
        dmem.addr      = {alu_res_q[63:3], 3'b000};
        if (is_store) begin
          dmem.wen   = 1'b1;
          dmem.wmask = size_mask << offset;
          dmem.wdata = store_data_q << {offset, 3'b000};
        end
        if (dmem.req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dmem.rsp_valid) begin
          load_data_d = mem_rd_q ? load_ext : 64'd0;
          state_d     = DONE;
        end
      end
      DONE: begin
        out_valid     = 1'b1;
        out_rd        = rd_q;
        out_funct3    = funct3_q;
        out_mem_rd    = mem_rd_q;
        out_mem_wr    = mem_wr_q;
        out_wb_sel    = wb_sel_q;
        out_alu_res   = alu_res_q;
        out_pc        = pc_q;
        out_inst      = inst_q;
        out_load_data = load_data_q;
        state_d       = IDLE;
      end
    endcase
  end

  // State and latched-instruction registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      wb_sel_q     <= 2'd0;
      alu_res_q    <= 64'd0;
      store_data_q <= 64'd0;
      pc_q         <= 64'd0;
      inst_q       <= 32'd0;
      load_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      wb_sel_q     <= wb_sel_d;
      alu_res_q    <= alu_res_d;
      store_data_q <= store_data_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      load_data_q  <= load_data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_mem_stage.sv
// Directed bench for the MEM stage.
// Each task scripts one instruction cycle by cycle and sets the expected
// outputs from a byte-level model. A negedge process compares every output on
// every cycle.
module tb_ysyx_22040125_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_mem_rd, in_mem_wr;
  logic [1:0]  in_wb_sel;
  logic [63:0] in_alu_res, in_store_data, in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_mem_rd, out_mem_wr;
  logic [1:0]  out_wb_sel;
  logic [63:0] out_alu_res, out_pc, out_load_data;
  logic [31:0] out_inst;
  logic        out_misalign;

  ysyx_22040125_mem_stage_if dmem_bus();

  ysyx_22040125_mem_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_wb_sel(in_wb_sel),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_pc(in_pc), .in_inst(in_inst),
    .dmem(dmem_bus),
    .out_valid(out_valid), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_wb_sel(out_wb_sel),
    .out_alu_res(out_alu_res), .out_pc(out_pc), .out_inst(out_inst),
    .out_load_data(out_load_data), .out_misalign(out_misalign)
  );

  int checks = 0;
  int errors = 0;

  // Expected values for the current cycle.
  logic        chk_en = 1'b0;
  logic        e_in_ready, e_out_valid, e_misalign, e_req_valid, e_wen;
  logic        e_mem_rd, e_mem_wr;
  logic [4:0]  e_rd;
  logic [2:0]  e_funct3;
  logic [1:0]  e_wb_sel;
  logic [63:0] e_alu_res, e_pc, e_load, e_addr, e_wdata;
  logic [31:0] e_inst;
  logic [7:0]  e_wmask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic model_misalign(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] sz;
    sz = 64'd1 << f3[1:0];
    return (a % sz) != 64'd0;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] rdata);
    int nb;
    int o;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    o  = int'(a[2:0]);
    v  = '0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = rdata[8*(o+b) +: 8];
    if (!f3[2] && nb < 8 && v[8*nb-1])
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [2:0] f3, input logic [63:0] a);
    int nb;
    int o;
    logic [7:0] m;
    nb = 1 << f3[1:0];
    o  = int'(a[2:0]);
    m  = '0;
    for (int b = 0; b < nb; b++) m[o+b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] a, input logic [63:0] d);
    int o;
    logic [63:0] w;
    o = int'(a[2:0]);
    w = '0;
    for (int b = o; b < 8; b++) w[8*b +: 8] = d[8*(b-o) +: 8];
    return w;
  endfunction

  // ---------------- expectation helpers ----------------
  task automatic exp_bubble();
    e_out_valid = 1'b0; e_misalign = 1'b0; e_rd = '0; e_funct3 = '0;
    e_mem_rd = 1'b0; e_mem_wr = 1'b0; e_wb_sel = '0; e_alu_res = '0;
    e_pc = '0; e_inst = '0; e_load = '0;
  endtask

  task automatic exp_no_req();
    e_req_valid = 1'b0; e_addr = '0; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
  endtask

  task automatic exp_idle();
    e_in_ready = 1'b1;
    exp_bubble();
    exp_no_req();
  endtask

  task automatic exp_fields();
    e_rd = in_rd; e_funct3 = in_funct3; e_mem_rd = in_mem_rd; e_mem_wr = in_mem_wr;
    e_wb_sel = in_wb_sel; e_alu_res = in_alu_res; e_pc = in_pc; e_inst = in_inst;
  endtask

  task automatic drive_in(input logic [4:0] rd, input logic [2:0] f3, input logic mrd,
                          input logic mwr, input logic [63:0] addr, input logic [63:0] sdata);
    in_valid = 1'b1; in_rd = rd; in_funct3 = f3; in_mem_rd = mrd; in_mem_wr = mwr;
    in_wb_sel = {mrd, 1'b1}; in_alu_res = addr; in_store_data = sdata;
    in_pc = 64'h8000_1000 + {59'd0, rd} * 4; in_inst = {addr[15:0], sdata[15:0]};
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, e_in_ready);
      chk("out_valid", out_valid, e_out_valid);
      chk("out_misalign", out_misalign, e_misalign);
      chk("out_rd", out_rd, e_rd);
      chk("out_funct3", out_funct3, e_funct3);
      chk("out_mem_rd", out_mem_rd, e_mem_rd);
      chk("out_mem_wr", out_mem_wr, e_mem_wr);
      chk("out_wb_sel", out_wb_sel, e_wb_sel);
      chk("out_alu_res", out_alu_res, e_alu_res);
      chk("out_pc", out_pc, e_pc);
      chk("out_inst", out_inst, e_inst);
      chk("out_load_data", out_load_data, e_load);
      chk("dmem_req_valid", dmem_bus.req_valid, e_req_valid);
      chk("dmem_addr", dmem_bus.addr, e_addr);
      chk("dmem_wen", dmem_bus.wen, e_wen);
      chk("dmem_wdata", dmem_bus.wdata, e_wdata);
      chk("dmem_wmask", dmem_bus.wmask, e_wmask);
    end
  end

  // ---------------- transactions ----------------
  task automatic do_pass(input logic [4:0] rd, input logic [2:0] f3, input logic mrd,
                         input logic mwr, input logic [63:0] addr);
    drive_in(rd, f3, mrd, mwr, addr, 64'h5555);
    exp_idle();
    e_out_valid = 1'b1;
    exp_fields();
    e_misalign = (mrd | mwr) && model_misalign(f3, addr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_idle();
    $display("pass-through rd=%0d f3=%0d rd/wr=%0d/%0d addr=0x%0h misalign=%0d",
             rd, f3, mrd, mwr, addr, e_misalign);
  endtask

  task automatic do_mem(input logic [4:0] rd, input logic [2:0] f3, input logic mrd,
                        input logic mwr, input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] rdata, input int rdly, input int sdly,
                        input logic rsp_in_hs);
    logic st;
    st = mwr & ~mrd;
    drive_in(rd, f3, mrd, mwr, addr, sdata);
    exp_idle();                                   // cycle T: accepted, bubble
    @(posedge clk); #1;
    e_in_ready  = 1'b0;
    e_req_valid = 1'b1;
    e_addr      = {addr[63:3], 3'b000};
    e_wen       = st;
    e_wmask     = st ? model_wmask(f3, addr) : 8'h00;
    e_wdata     = st ? model_wdata(addr, sdata) : 64'd0;
    for (int i = 0; i <= rdly; i++) begin         // REQ
      dmem_bus.req_ready = (i == rdly);
      dmem_bus.rsp_valid = (i == rdly) && rsp_in_hs;
      dmem_bus.rdata     = ~rdata;
      @(posedge clk); #1;
    end
    dmem_bus.req_ready = 1'b0;
    exp_no_req();
    for (int j = 0; j <= sdly; j++) begin         // WAIT
      dmem_bus.rsp_valid = (j == sdly);
      dmem_bus.rdata     = (j == sdly) ? rdata : 64'hA5A5_5A5A_F0F0_0F0F;
      @(posedge clk); #1;
    end
    dmem_bus.rsp_valid = 1'b0;
    dmem_bus.rdata     = '0;
    e_out_valid = 1'b1;                           // DONE
    exp_fields();
    e_load = mrd ? model_load(f3, addr, rdata) : 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_idle();
    $display("mem op rd=%0d f3=%0d rd/wr=%0d/%0d addr=0x%0h rdly=%0d sdly=%0d load=0x%0h",
             rd, f3, mrd, mwr, addr, rdly, sdly, e_load);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_funct3 = '0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
    in_wb_sel = '0; in_alu_res = '0; in_store_data = '0; in_pc = '0; in_inst = '0;
    dmem_bus.req_ready = 1'b0; dmem_bus.rsp_valid = 1'b0; dmem_bus.rdata = '0;
    exp_idle();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed pins on the model itself. The byte at offset 3 of
    // 0x80FF0000 is 0x80, so LB at ...03 yields ...FF80; offset 2 holds 0xFF.
    chk("pin_lb_off3", model_load(3'b000, 64'h8000_0003, 64'h0000_0000_80FF_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("pin_lb_off2", model_load(3'b000, 64'h8000_0002, 64'h0000_0000_80FF_0000), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_lhu", model_load(3'b101, 64'h8000_0006, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);
    chk("pin_sw_mask", {56'd0, model_wmask(3'b010, 64'h8000_0004)}, 64'h0000_0000_0000_00F0);
    chk("pin_sw_data", model_wdata(64'h8000_0004, 64'h1122_3344), 64'h1122_3344_0000_0000);
    chk("pin_ld_misalign", {63'd0, model_misalign(3'b011, 64'h8000_0004)}, 64'd1);

    do_pass(5'd5, 3'b000, 1'b0, 1'b0, 64'h1234);
    do_mem(5'd1, 3'b000, 1'b1, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 0, 0, 1'b0);
    do_mem(5'd2, 3'b000, 1'b1, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_80FF_0000, 0, 0, 1'b0);
    do_mem(5'd3, 3'b101, 1'b1, 1'b0, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 0, 1'b0);
    do_mem(5'd0, 3'b010, 1'b0, 1'b1, 64'h8000_0004, 64'h1122_3344, 64'hDEAD_BEEF_0000_1111, 3, 0, 1'b0);
    do_pass(5'd7, 3'b011, 1'b1, 1'b0, 64'h8000_0004);
    do_pass(5'd0, 3'b001, 1'b0, 1'b1, 64'h8000_0001);
    do_mem(5'd8, 3'b010, 1'b1, 1'b0, 64'h8000_0008, 64'd0, 64'h1234_5678_F000_0001, 1, 2, 1'b1);
    do_mem(5'd0, 3'b000, 1'b0, 1'b1, 64'h8000_0005, 64'h0000_0000_0000_77AB, 64'd0, 0, 1, 1'b0);
    do_mem(5'd9, 3'b111, 1'b1, 1'b1, 64'h8000_0010, 64'hFFFF, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0);
    do_mem(5'd0, 3'b011, 1'b0, 1'b1, 64'h8000_0018, 64'hCAFE_BABE_DEAD_BEEF, 64'd0, 2, 1, 1'b0);
    do_mem(5'd10, 3'b100, 1'b1, 1'b0, 64'h8000_0007, 64'd0, 64'h9A00_0000_0000_0000, 0, 0, 1'b0);
    do_mem(5'd11, 3'b001, 1'b1, 1'b0, 64'h8000_0002, 64'd0, 64'h0000_0000_8001_0000, 0, 0, 1'b0);

    // Reset while an access is in WAIT: the stage aborts immediately and
    // ignores the late response.
    drive_in(5'd12, 3'b011, 1'b1, 1'b0, 64'h8000_0020, 64'd0);
    exp_idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    dmem_bus.req_ready = 1'b1;
    e_in_ready = 1'b0; e_req_valid = 1'b1; e_addr = 64'h8000_0020;
    @(posedge clk); #1;
    dmem_bus.req_ready = 1'b0;
    exp_no_req();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_in_ready", in_ready, 1'b1);
    chk("rst_async_out_valid", out_valid, 1'b0);
    chk("rst_async_req_valid", dmem_bus.req_valid, 1'b0);
    exp_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #1;
    dmem_bus.rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("reset-in-WAIT abort and stale response");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
